// File: rtl/cgra0_input_fetch.sv
// cgra0_input_fetch
// Per-queue input stream fetcher for one CGRA input lane. When a run starts
// it reads num_data words from memory over a valid/ready read port into a
// small show-ahead FIFO. It reports the status bits that the controller uses
// to build its global enable.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start             level fetch enable, held high for the whole run
//   base_addr         first word address (sampled on run start)
//   num_data          words to fetch (sampled on run start)
//   rd_req/rd_addr    read request, held stable until rd_req_ready
//   rd_req_ready      request accepted when rd_req & rd_req_ready
//   rd_data_valid     one in-order response word per high cycle
//   rd_data           response word
//   pop               consume the head word
//   dout              head word (0 while the FIFO is empty)
//   available_read    buffered count > AE_THRESH (registered)
//   available_pop     FIFO full, or every remaining word buffered (registered)
//   read_fifo_done    all words popped; clears when start drops (registered)
//   err               only with CGRA_FETCH_ERR_EN: sticky flag for a pop on
//                     an empty FIFO or a response with no request outstanding
//
// Build option: define CGRA_FETCH_ERR_EN to add the err output.
module cgra0_input_fetch #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 32,
  parameter int DEPTH      = 8,
  parameter int AE_THRESH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  num_data,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_req_ready,
  input  logic                  rd_data_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  available_read,
  output logic                  available_pop,
`ifdef CGRA_FETCH_ERR_EN
  output logic                  err,
`endif
  output logic                  read_fifo_done
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                       state_q, state_d;
  logic [LEN_WIDTH-1:0]             num_q, num_d;
  logic [LEN_WIDTH-1:0]             req_cnt_q, req_cnt_d;
  logic [LEN_WIDTH-1:0]             rsp_cnt_q, rsp_cnt_d;
  logic [LEN_WIDTH-1:0]             pop_cnt_q, pop_cnt_d;
  logic [ADDR_WIDTH-1:0]            addr_q, addr_d;
  logic                             rd_req_q, rd_req_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]                    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                    count_q, count_d;
  logic                             avail_read_q, avail_read_d;
  logic                             avail_pop_q, avail_pop_d;
  logic                             done_q, done_d;

  logic                             accept, outstanding, push, do_pop;
  logic [LEN_WIDTH-1:0]             committed;

  always_comb begin
    accept      = rd_req_q & rd_req_ready;
    outstanding = (req_cnt_q != rsp_cnt_q);
    // Responses are taken only inside a run and only against a request in
    // flight; anything else is a stray word and is dropped.
    push        = rd_data_valid & (state_q != S_IDLE) & outstanding;
    do_pop      = pop & (count_q != '0);

    state_d   = state_q;
    num_d     = num_q;
    req_cnt_d = req_cnt_q + LEN_WIDTH'(accept);
    rsp_cnt_d = rsp_cnt_q + LEN_WIDTH'(push);
    pop_cnt_d = pop_cnt_q + LEN_WIDTH'(do_pop);
    addr_d    = addr_q + ADDR_WIDTH'(accept);
    mem_d     = mem_q;
    if (push) mem_d[wr_ptr_q] = rd_data;
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(do_pop);
    count_d   = count_q + CW'(push) - CW'(do_pop);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d     = num_data;
          addr_d    = base_addr;
          req_cnt_d = '0;
          rsp_cnt_d = '0;
          pop_cnt_d = '0;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          count_d   = '0;
          state_d   = (num_data == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (req_cnt_q == num_q) state_d = (pop_cnt_d == num_q) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (pop_cnt_d == num_q) state_d = S_DONE;
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Words that will be buffered or in flight after this edge. Issuing only
    // while this stays below DEPTH guarantees every response has a slot.
    committed = LEN_WIDTH'(count_d) + (req_cnt_d - rsp_cnt_d);
    rd_req_d  = (rd_req_q & ~rd_req_ready) |
                ((state_q == S_FETCH) & (req_cnt_d < num_q) &
                 (committed < LEN_WIDTH'(DEPTH)));

    avail_read_d = (count_q > CW'(AE_THRESH));
    avail_pop_d  = (count_q == CW'(DEPTH)) |
                   ((state_q != S_IDLE) & (rsp_cnt_q == num_q) & (count_q != '0));
    // Clears on the same edge that DONE returns to IDLE.
    done_d       = (state_q == S_DONE) & start;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      num_q        <= '0;
      req_cnt_q    <= '0;
      rsp_cnt_q    <= '0;
      pop_cnt_q    <= '0;
      addr_q       <= '0;
      rd_req_q     <= 1'b0;
      mem_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      avail_read_q <= 1'b0;
      avail_pop_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      req_cnt_q    <= req_cnt_d;
      rsp_cnt_q    <= rsp_cnt_d;
      pop_cnt_q    <= pop_cnt_d;
      addr_q       <= addr_d;
      rd_req_q     <= rd_req_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      avail_read_q <= avail_read_d;
      avail_pop_q  <= avail_pop_d;
      done_q       <= done_d;
    end
  end

`ifdef CGRA_FETCH_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (pop & (count_q == '0)) | (rd_data_valid & ~outstanding);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;
`endif

  assign rd_req         = rd_req_q;
  assign rd_addr        = addr_q;
  assign dout           = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign available_read = avail_read_q;
  assign available_pop  = avail_pop_q;
  assign read_fifo_done = done_q;

endmodule

// File: tb/tb_cgra0_input_fetch.sv
module tb_cgra0_input_fetch;
  localparam int DW = 16, AW = 32, LW = 32, DEPTH = 8, AE = 3;
  localparam int P_IDLE = 0, P_ACT = 1, P_DONE = 2;

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic          rd_req_ready = 1'b0, rd_data_valid = 1'b0, pop = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] num_data = '0;
  logic [DW-1:0] rd_data = '0;
  logic          rd_req, available_read, available_pop, read_fifo_done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] dout;
`ifdef CGRA_FETCH_ERR_EN
  logic err;
  bit   err_m = 1'b0;
`endif

  int checks = 0, failures = 0;

  // Reference model: a run is a phase plus counts; the FIFO is a queue of the
  // words expected at memory addresses base, base+1, ...
  int            phase = P_IDLE, num_m = 0, issued = 0, popped = 0, rsp = 0, cyc = 0;
  logic [AW-1:0] base_m = '0;
  logic [DW-1:0] fifo_m[$];
  logic [AW-1:0] mem_addr[$];
  int            mem_due[$];
  int            ready_pct = 100, lat_max = 1, pop_pct = 0;

  always #5 clk = ~clk;

  cgra0_input_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
                      .DEPTH(DEPTH), .AE_THRESH(AE)) u_dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_data(num_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_req_ready(rd_req_ready),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .pop(pop), .dout(dout),
    .available_read(available_read), .available_pop(available_pop),
`ifdef CGRA_FETCH_ERR_EN
    .err(err),
`endif
    .read_fifo_done(read_fifo_done));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return (a[15:0] ^ 16'hA55A) + a[31:16];
  endfunction

  // One clock: drive inputs, advance, update the model, check all outputs.
  task automatic step();
    bit            acc, psh, dpop, st, exp_req;
    int            ph0, cnt0, rsp0, num0, c0;
    logic [AW-1:0] a0;
    rd_req_ready = ($urandom_range(1, 100) <= ready_pct);
    pop          = ($urandom_range(1, 100) <= pop_pct);
    if (mem_addr.size() > 0 && mem_due[0] <= cyc) begin
      rd_data_valid = 1'b1;
      rd_data       = word_of(mem_addr[0]);
    end else begin
      rd_data_valid = 1'b0;
      rd_data       = DW'($urandom);
    end
    acc  = rd_req && rd_req_ready;
    psh  = rd_data_valid;
    dpop = pop && (fifo_m.size() > 0);
    a0   = rd_addr;
    if (dpop) chk("pop_head", dout, fifo_m[0]);
`ifdef CGRA_FETCH_ERR_EN
    if (pop && fifo_m.size() == 0) err_m = 1'b1;
`endif
    ph0 = phase; cnt0 = fifo_m.size(); rsp0 = rsp; num0 = num_m; st = start; c0 = cyc;

    @(posedge clk);
    cyc++;
    if (phase == P_IDLE) begin
      if (start) begin
        phase  = (num_data == 0) ? P_DONE : P_ACT;
        num_m  = int'(num_data);
        base_m = base_addr;
        issued = 0; popped = 0; rsp = 0;
        fifo_m.delete();
      end
    end else begin
      if (psh) begin
        fifo_m.push_back(word_of(base_m + AW'(rsp)));
        rsp++;
      end
      if (acc) issued++;
      if (dpop) begin
        void'(fifo_m.pop_front());
        popped++;
      end
      if (phase == P_ACT && popped == num_m) phase = P_DONE;
      else if (phase == P_DONE && !start)    phase = P_IDLE;
    end
    if (psh) begin
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
    end
    if (acc) begin
      mem_addr.push_back(a0);
      mem_due.push_back(c0 + $urandom_range(1, lat_max));
    end

    #1;
    chk("dout", dout, (fifo_m.size() > 0) ? fifo_m[0] : 16'h0);
    exp_req = (ph0 == P_ACT) && (issued < num_m) && ((issued - popped) < DEPTH);
    chk("rd_req", rd_req, exp_req);
    if (exp_req) chk("rd_addr", rd_addr, base_m + AW'(issued));
    chk("avail_read", available_read, cnt0 > AE);
    chk("avail_pop", available_pop,
        (cnt0 == DEPTH) || (ph0 != P_IDLE && rsp0 == num0 && cnt0 != 0));
    chk("done", read_fifo_done, (ph0 == P_DONE) && st);
`ifdef CGRA_FETCH_ERR_EN
    chk("err", err, err_m);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; pop = 1'b0; rd_data_valid = 1'b0; rd_req_ready = 1'b0;
    #2;
    chk("rst_req", rd_req, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_dout", dout, 0);
    chk("rst_aread", available_read, 0);
    chk("rst_apop", available_pop, 0);
    chk("rst_done", read_fifo_done, 0);
`ifdef CGRA_FETCH_ERR_EN
    chk("rst_err", err, 0);
    err_m = 1'b0;
`endif
    phase = P_IDLE; num_m = 0; issued = 0; popped = 0; rsp = 0;
    fifo_m.delete(); mem_addr.delete(); mem_due.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic begin_run(input int n, input logic [AW-1:0] b);
    num_data = LW'(n); base_addr = b; start = 1'b1;
    step(); chk("req_lat1", rd_req, 0);
    step(); chk("req_lat2", rd_req, n != 0);
    // Only the run-start values may matter from here on.
    base_addr = $urandom; num_data = $urandom;
  endtask

  task automatic finish_run(input int budget);
    int k = 0;
    while (phase != P_DONE && k < budget) begin
      step();
      k++;
    end
    step();
    chk("run_done", read_fifo_done, 1);
    start = 1'b0;
    step();
    chk("done_clr", read_fifo_done, 0);
    step();
  endtask

  initial begin
    #1;
    do_reset();

    // Back-to-back fetch of 5 words, no pops, then in-order drain.
    ready_pct = 100; lat_max = 1; pop_pct = 0;
    begin_run(5, 32'h100);
    for (int k = 0; k < 20 && fifo_m.size() < 5; k++) step();
    step();
    chk("a_issued", issued, 5);
    chk("a_apop", available_pop, 1);
    chk("a_aread", available_read, 1);
    pop_pct = 100;
    finish_run(40);

    // Credit limit: 20 words, depth 8, no pops.
    pop_pct = 0;
    begin_run(20, 32'h2000);
    repeat (30) step();
    chk("b_cap", issued, DEPTH);
    chk("b_req_low", rd_req, 0);
    chk("b_full_apop", available_pop, 1);
    pop_pct = 100; step(); pop_pct = 0;
    repeat (6) step();
    chk("b_one_more", issued, DEPTH + 1);
    pop_pct = 70;
    finish_run(200);

    // Zero-length run.
    pop_pct = 0;
    begin_run(0, 32'h500);
    chk("zero_done", read_fifo_done, 1);
    chk("zero_issued", issued, 0);
    finish_run(5);

    // Memory not ready: request and address must hold.
    ready_pct = 0;
    begin_run(6, 32'h600);
    repeat (5) begin
      step();
      chk("stall_req", rd_req, 1);
      chk("stall_addr", rd_addr, 32'h600);
    end
    ready_pct = 100; pop_pct = 50;
    finish_run(100);

    // Reset mid-run with 3 words buffered, then a fresh 2-word run.
    pop_pct = 0;
    begin_run(10, 32'h700);
    for (int k = 0; k < 20 && fifo_m.size() < 3; k++) step();
    do_reset();
    begin_run(2, 32'h800);
    pop_pct = 100;
    finish_run(40);
    chk("e_popped", popped, 2);

    // Randomized runs, including an address wrap.
    for (int r = 0; r < 8; r++) begin
      int n;
      ready_pct = $urandom_range(30, 100);
      lat_max   = $urandom_range(1, 5);
      pop_pct   = $urandom_range(20, 90);
      n         = $urandom_range(1, 30);
      begin_run(n, (r == 0) ? 32'hFFFF_FFFC : AW'($urandom));
      finish_run(40 * n + 100);
    end

`ifdef CGRA_FETCH_ERR_EN
    ready_pct = 100; lat_max = 1; pop_pct = 100;
    step();
    pop_pct = 0;
    step();
    chk("err_set", err, 1);
    repeat (3) step();
    chk("err_sticky", err, 1);
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
